// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, control bundle layout and select encodings for ctrl_pipe
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] WordWork = 2'b01;
    localparam logic [1:0] ByteWork = 2'b10;

    localparam int WB_W = 2;
    localparam int M_W  = 4;
    localparam int EX_W = 8;

    localparam int WB_MEMTOREG_BIT = 1;
    localparam int WB_REGWRITE_BIT = 0;
    localparam int M_READ_LSB      = 2;
    localparam int M_WRITE_LSB     = 0;
    localparam int EX_ALUSRC_BIT   = 7;
    localparam int EX_ALUOP_LSB    = 1;
    localparam int EX_REGDST_BIT   = 0;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_t;

    typedef struct packed {
        logic [1:0] mem_read;
        logic [1:0] mem_write;
    } m_t;

    typedef struct packed {
        logic       alusrc;
        logic [5:0] aluop;
        logic       regdst;
    } ex_t;

    typedef struct packed {
        wb_t wb;
        m_t  m;
        ex_t ex;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - decoder-side inputs and per-stage datapath control of ctrl_pipe
interface ctrl_pipe_if #(
    parameter int REG_W = 5
);
    logic [1:0]       id_wb;
    logic [3:0]       id_m;
    logic [7:0]       id_ex;
    logic             id_jump;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             flush;
    logic             stall;
    logic             ex_alusrc;
    logic [5:0]       ex_aluop;
    logic             ex_regdst;
    logic [1:0]       mem_read;
    logic [1:0]       mem_write;
    logic             wb_memtoreg;
    logic             wb_regwrite;
    logic [REG_W-1:0] wb_dest;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    modport master (
        output id_wb, id_m, id_ex, id_jump, id_rs, id_rt, id_rd, flush,
        input  stall, ex_alusrc, ex_aluop, ex_regdst, mem_read, mem_write,
               wb_memtoreg, wb_regwrite, wb_dest, fwd_a, fwd_b
    );

    modport slave (
        input  id_wb, id_m, id_ex, id_jump, id_rs, id_rt, id_rd, flush,
        output stall, ex_alusrc, ex_aluop, ex_regdst, mem_read, mem_write,
               wb_memtoreg, wb_regwrite, wb_dest, fwd_a, fwd_b
    );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational stall and forwarding-select logic
// CTRL_PIPE_FWD_EN: forwarding selects live, only load-use stalls; otherwise any RAW stalls.
module hazard_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [1:0]       idex_mem_read_i,
    input  logic             idex_regwrite_i,
    input  logic [REG_W-1:0] idex_dest_i,
    input  logic [REG_W-1:0] idex_rs_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             exmem_regwrite_i,
    input  logic [REG_W-1:0] exmem_dest_i,
    input  logic             memwb_regwrite_i,
    input  logic [REG_W-1:0] memwb_dest_i,
    output logic             stall_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    // Register 0 is hardwired, so a $0 destination never produces a dependency.
    function automatic logic hit(input logic wr, input logic [REG_W-1:0] dest,
                                 input logic [REG_W-1:0] src);
        return wr && (dest != '0) && (dest == src);
    endfunction

    logic load_use;
    assign load_use = hit(idex_mem_read_i != 2'b00, idex_dest_i, id_rs_i)
                    | hit(idex_mem_read_i != 2'b00, idex_dest_i, id_rt_i);

`ifdef CTRL_PIPE_FWD_EN
    always_comb begin
        fwd_a_o = FWD_REG;
        fwd_b_o = FWD_REG;
        if (hit(exmem_regwrite_i, exmem_dest_i, idex_rs_i)) begin
            fwd_a_o = FWD_EXMEM;
        end else if (hit(memwb_regwrite_i, memwb_dest_i, idex_rs_i)) begin
            fwd_a_o = FWD_MEMWB;
        end
        if (hit(exmem_regwrite_i, exmem_dest_i, idex_rt_i)) begin
            fwd_b_o = FWD_EXMEM;
        end else if (hit(memwb_regwrite_i, memwb_dest_i, idex_rt_i)) begin
            fwd_b_o = FWD_MEMWB;
        end
    end

    assign stall_o = load_use;

    logic unused_raw;
    assign unused_raw = idex_regwrite_i;
`else
    assign stall_o = load_use
                   | hit(idex_regwrite_i,  idex_dest_i,  id_rs_i)
                   | hit(idex_regwrite_i,  idex_dest_i,  id_rt_i)
                   | hit(exmem_regwrite_i, exmem_dest_i, id_rs_i)
                   | hit(exmem_regwrite_i, exmem_dest_i, id_rt_i);
    assign fwd_a_o = FWD_REG;
    assign fwd_b_o = FWD_REG;

    logic unused_fwd;
    assign unused_fwd = ^{idex_rs_i, idex_rt_i, memwb_regwrite_i, memwb_dest_i};
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall and flush
// Forwarding selects are generated only when CTRL_PIPE_FWD_EN is defined.
module ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int JAL_REG = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    ctrl_pipe_if.slave  bus
);

    localparam logic [REG_W-1:0] JAL_DEST = REG_W'(JAL_REG);

    typedef struct packed {
        ctrl_t            ctrl;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } idex_t;

    typedef struct packed {
        wb_t              wb;
        m_t               m;
        logic [REG_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        wb_t              wb;
        logic [REG_W-1:0] dest;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    ctrl_t            id_ctrl;
    logic [REG_W-1:0] id_dest;
    logic             stall;

    assign id_ctrl = ctrl_t'({bus.id_wb, bus.id_m, bus.id_ex});

    always_comb begin
        id_dest = bus.id_rt;
        if (bus.id_jump && id_ctrl.wb.regwrite) begin
            id_dest = JAL_DEST;
        end else if (id_ctrl.ex.regdst) begin
            id_dest = bus.id_rd;
        end
    end

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs_i          (bus.id_rs),
        .id_rt_i          (bus.id_rt),
        .idex_mem_read_i  (idex_q.ctrl.m.mem_read),
        .idex_regwrite_i  (idex_q.ctrl.wb.regwrite),
        .idex_dest_i      (idex_q.dest),
        .idex_rs_i        (idex_q.rs),
        .idex_rt_i        (idex_q.rt),
        .exmem_regwrite_i (exmem_q.wb.regwrite),
        .exmem_dest_i     (exmem_q.dest),
        .memwb_regwrite_i (memwb_q.wb.regwrite),
        .memwb_dest_i     (memwb_q.dest),
        .stall_o          (stall),
        .fwd_a_o          (bus.fwd_a),
        .fwd_b_o          (bus.fwd_b)
    );

    // Flush or stall only replaces the ID/EX entry; later stages always advance.
    always_comb begin
        idex_d = '0;
        idex_d.ctrl = CTRL_BUBBLE;
        if (!(bus.flush || stall)) begin
            idex_d.ctrl = id_ctrl;
            idex_d.dest = id_dest;
            idex_d.rs   = bus.id_rs;
            idex_d.rt   = bus.id_rt;
        end
        exmem_d = {idex_q.ctrl.wb, idex_q.ctrl.m, idex_q.dest};
        memwb_d = {exmem_q.wb, exmem_q.dest};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_alusrc   = idex_q.ctrl.ex.alusrc;
    assign bus.ex_aluop    = idex_q.ctrl.ex.aluop;
    assign bus.ex_regdst   = idex_q.ctrl.ex.regdst;
    assign bus.mem_read    = exmem_q.m.mem_read;
    assign bus.mem_write   = exmem_q.m.mem_write;
    assign bus.wb_memtoreg = memwb_q.wb.memtoreg;
    assign bus.wb_regwrite = memwb_q.wb.regwrite;
    assign bus.wb_dest     = memwb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe against an instruction-level model
module tb_ctrl_pipe;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_W(5)) bus ();

    ctrl_pipe #(.REG_W(5), .JAL_REG(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit       memtoreg, regwrite, jump, alusrc, regdst;
        bit [1:0] mrd, mwr;
        bit [5:0] aluop;
        int       rs, rt, rd;
    } instr_t;

    typedef struct {
        bit       memtoreg, regwrite, alusrc, regdst;
        bit [1:0] mrd, mwr;
        bit [5:0] aluop;
        int       dest, rs, rt;
    } slot_t;

    // Instructions occupying EX, MEM and WB in the reference model.
    slot_t st_ex, st_mem, st_wb;
    bit    last_stall;

    function automatic instr_t mk_nop();
        instr_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic instr_t mk_rtype(int rs, int rt, int rd);
        instr_t i = mk_nop();
        i.regwrite = 1; i.regdst = 1; i.aluop = OP_RTYPE;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t mk_addi(int rs, int rt);
        instr_t i = mk_nop();
        i.regwrite = 1; i.alusrc = 1; i.aluop = OP_ADDI;
        i.rs = rs; i.rt = rt; i.rd = ($urandom_range(0, 31));
        return i;
    endfunction

    function automatic instr_t mk_lw(int rs, int rt);
        instr_t i = mk_addi(rs, rt);
        i.memtoreg = 1; i.mrd = WordWork; i.aluop = OP_LW;
        return i;
    endfunction

    function automatic instr_t mk_store(int rs, int rt, bit is_byte);
        instr_t i = mk_nop();
        i.alusrc = 1; i.mwr = is_byte ? ByteWork : WordWork;
        i.aluop = is_byte ? OP_SB : OP_SW;
        i.rs = rs; i.rt = rt; i.rd = $urandom_range(0, 31);
        return i;
    endfunction

    function automatic instr_t mk_jal();
        instr_t i = mk_nop();
        i.regwrite = 1; i.jump = 1; i.aluop = OP_JAL;
        i.rs = $urandom_range(0, 31); i.rt = $urandom_range(0, 31); i.rd = $urandom_range(0, 31);
        return i;
    endfunction

    function automatic slot_t bubble();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic slot_t enter(instr_t i);
        slot_t s;
        s.memtoreg = i.memtoreg; s.regwrite = i.regwrite;
        s.alusrc = i.alusrc; s.regdst = i.regdst;
        s.mrd = i.mrd; s.mwr = i.mwr; s.aluop = i.aluop;
        s.rs = i.rs; s.rt = i.rt;
        if (i.jump && i.regwrite) s.dest = 31;
        else if (i.regdst)        s.dest = i.rd;
        else                      s.dest = i.rt;
        return s;
    endfunction

    function automatic bit writes(slot_t s, int r);
        return s.regwrite && s.dest != 0 && s.dest == r;
    endfunction

    function automatic bit exp_stall(instr_t i);
        bit lu;
        lu = (st_ex.mrd != 0) && st_ex.dest != 0 && (st_ex.dest == i.rs || st_ex.dest == i.rt);
`ifdef CTRL_PIPE_FWD_EN
        return lu;
`else
        return lu || writes(st_ex, i.rs) || writes(st_ex, i.rt)
                  || writes(st_mem, i.rs) || writes(st_mem, i.rt);
`endif
    endfunction

    function automatic bit [1:0] exp_fwd(int r);
`ifdef CTRL_PIPE_FWD_EN
        if (writes(st_mem, r)) return 2'b10;
        if (writes(st_wb, r))  return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic drive(instr_t i, bit fl);
        bus.id_wb   = {i.memtoreg, i.regwrite};
        bus.id_m    = {i.mrd, i.mwr};
        bus.id_ex   = {i.alusrc, i.aluop, i.regdst};
        bus.id_jump = i.jump;
        bus.id_rs   = 5'(i.rs);
        bus.id_rt   = 5'(i.rt);
        bus.id_rd   = 5'(i.rd);
        bus.flush   = fl;
    endtask

    task automatic model_reset();
        st_ex = bubble(); st_mem = bubble(); st_wb = bubble();
    endtask

    // One ID presentation: compare every output with the model mid-cycle, then clock both.
    task automatic issue(instr_t i, bit fl);
        bit       s_e;
        bit [7:0] ex_e;
        bit [3:0] m_e;
        bit [6:0] wb_e;
        drive(i, fl);
        @(negedge clk);
        s_e  = exp_stall(i);
        ex_e = {st_ex.alusrc, st_ex.aluop, st_ex.regdst};
        m_e  = {st_mem.mrd, st_mem.mwr};
        wb_e = {st_wb.memtoreg, st_wb.regwrite, 5'(st_wb.dest)};
        n_tests++;
        if (bus.stall !== s_e) begin
            n_fail++; $display("FAIL stall: got %0b expected %0b at %0t", bus.stall, s_e, $time);
        end
        n_tests++;
        if ({bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst} !== ex_e) begin
            n_fail++; $display("FAIL ex_ctrl: got %0h expected %0h at %0t",
                               {bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst}, ex_e, $time);
        end
        n_tests++;
        if ({bus.mem_read, bus.mem_write} !== m_e) begin
            n_fail++; $display("FAIL mem_ctrl: got %0h expected %0h at %0t",
                               {bus.mem_read, bus.mem_write}, m_e, $time);
        end
        n_tests++;
        if ({bus.wb_memtoreg, bus.wb_regwrite, bus.wb_dest} !== wb_e) begin
            n_fail++; $display("FAIL wb_ctrl: got %0h expected %0h at %0t",
                               {bus.wb_memtoreg, bus.wb_regwrite, bus.wb_dest}, wb_e, $time);
        end
        n_tests++;
        if ({bus.fwd_a, bus.fwd_b} !== {exp_fwd(st_ex.rs), exp_fwd(st_ex.rt)}) begin
            n_fail++; $display("FAIL fwd: got %0h expected %0h at %0t", {bus.fwd_a, bus.fwd_b},
                               {exp_fwd(st_ex.rs), exp_fwd(st_ex.rt)}, $time);
        end
        last_stall = bus.stall;
        @(posedge clk);
        st_wb  = st_mem;
        st_mem = st_ex;
        st_ex  = (fl || s_e) ? bubble() : enter(i);
        #1;
    endtask

    task automatic drain();
        repeat (3) issue(mk_nop(), 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(mk_lw(8, 8), 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if ({bus.stall, bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst, bus.mem_read, bus.mem_write,
             bus.wb_memtoreg, bus.wb_regwrite, bus.wb_dest, bus.fwd_a, bus.fwd_b} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero output in reset, expected all 0");
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_addi();
        issue(mk_addi(0, 5), 1'b0);
        n_tests++;
        if ({bus.ex_alusrc, bus.ex_aluop} !== 7'b1_001000) begin
            n_fail++; $display("FAIL addi_ex: got %0b expected 1001000", {bus.ex_alusrc, bus.ex_aluop});
        end
        issue(mk_nop(), 1'b0);
        issue(mk_nop(), 1'b0);
        n_tests++;
        if ({bus.wb_regwrite, bus.wb_dest} !== {1'b1, 5'd5}) begin
            n_fail++; $display("FAIL addi_wb: got %0h expected 25", {bus.wb_regwrite, bus.wb_dest});
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        int zero_slot = 0;
        int exp_stalls;
`ifdef CTRL_PIPE_FWD_EN
        exp_stalls = 1;
`else
        exp_stalls = 2;
`endif
        drain();
        issue(mk_lw(1, 8), 1'b0);
        for (int k = 0; k < 4; k++) begin
            issue(mk_rtype(8, 2, 9), 1'b0);
            if (!last_stall) break;
            stalls++;
            if ({bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst} == 8'h00) zero_slot++;
        end
        n_tests++;
        if (stalls != exp_stalls || zero_slot != exp_stalls) begin
            n_fail++; $display("FAIL load_use_stall: got %0d stalls/%0d empty EX slots expected %0d",
                               stalls, zero_slot, exp_stalls);
        end
        n_tests++;
        if ({bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst} !== 8'b0_000000_1) begin
            n_fail++; $display("FAIL load_use_add_ex: got %0h expected 01",
                               {bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst});
        end
    endtask

    task automatic test_jal();
        drain();
        issue(mk_jal(), 1'b0);
        issue(mk_nop(), 1'b0);
        issue(mk_nop(), 1'b0);
        n_tests++;
        if ({bus.wb_regwrite, bus.wb_dest} !== {1'b1, 5'd31}) begin
            n_fail++; $display("FAIL jal_wb: got %0h expected 3f", {bus.wb_regwrite, bus.wb_dest});
        end
    endtask

    task automatic test_flush_sw();
        drain();
        issue(mk_store(1, 2, 1'b0), 1'b1);
        n_tests++;
        if ({bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst} !== 8'h00) begin
            n_fail++; $display("FAIL flush_ex: got %0h expected 0",
                               {bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst});
        end
        issue(mk_nop(), 1'b0);
        n_tests++;
        if (bus.mem_write !== 2'b00) begin
            n_fail++; $display("FAIL flush_mem_write: got %0b expected 00", bus.mem_write);
        end
    endtask

    task automatic test_forwarding();
        drain();
        issue(mk_rtype(1, 2, 3), 1'b0);
        issue(mk_rtype(3, 4, 5), 1'b0);
`ifdef CTRL_PIPE_FWD_EN
        n_tests++;
        if (last_stall !== 1'b0 || {bus.fwd_a, bus.fwd_b} !== 4'b10_00) begin
            n_fail++; $display("FAIL fwd_exmem: got stall %0b fwd %0b expected stall 0 fwd 1000",
                               last_stall, {bus.fwd_a, bus.fwd_b});
        end
        drain();
        issue(mk_rtype(1, 2, 6), 1'b0);
        issue(mk_nop(), 1'b0);
        issue(mk_rtype(7, 6, 9), 1'b0);
        n_tests++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b00_01) begin
            n_fail++; $display("FAIL fwd_memwb: got %0b expected 0001", {bus.fwd_a, bus.fwd_b});
        end
`else
        n_tests++;
        if (last_stall !== 1'b1 || {bus.fwd_a, bus.fwd_b} !== 4'b0000) begin
            n_fail++; $display("FAIL raw_stall: got stall %0b fwd %0b expected stall 1 fwd 0000",
                               last_stall, {bus.fwd_a, bus.fwd_b});
        end
        for (int k = 0; k < 4 && last_stall; k++) issue(mk_rtype(3, 4, 5), 1'b0);
`endif
    endtask

    task automatic test_zero_dest();
        drain();
        issue(mk_lw(1, 0), 1'b0);
        issue(mk_rtype(0, 0, 1), 1'b0);
        n_tests++;
        if (last_stall !== 1'b0) begin
            n_fail++; $display("FAIL zero_dest_stall: got %0b expected 0", last_stall);
        end
        issue(mk_addi(2, 0), 1'b0);
        issue(mk_rtype(0, 0, 4), 1'b0);
        n_tests++;
        if (last_stall !== 1'b0 || {bus.fwd_a, bus.fwd_b} !== 4'b0000) begin
            n_fail++; $display("FAIL zero_dest_fwd: got stall %0b fwd %0b expected 0 0000",
                               last_stall, {bus.fwd_a, bus.fwd_b});
        end
    endtask

    task automatic test_random();
        instr_t i;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0:       i = mk_nop();
                1:       i = mk_rtype($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                2:       i = mk_addi($urandom_range(0, 3), $urandom_range(0, 3));
                3:       i = mk_lw($urandom_range(0, 3), $urandom_range(0, 3));
                4:       i = mk_store($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                5:       i = mk_jal();
                default: i = mk_rtype($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
            issue(i, $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic test_async_reset();
        drain();
        issue(mk_store(1, 2, 1'b1), 1'b0);
        issue(mk_nop(), 1'b0);
        n_tests++;
        if (bus.mem_write !== ByteWork) begin
            n_fail++; $display("FAIL sb_in_mem: got %0b expected 10", bus.mem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_write, bus.mem_read, bus.wb_regwrite, bus.ex_alusrc, bus.stall} !== '0) begin
            n_fail++; $display("FAIL async_reset: got %0h expected 0",
                               {bus.mem_write, bus.mem_read, bus.wb_regwrite, bus.ex_alusrc, bus.stall});
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
    endtask

    initial begin
        last_stall = 1'b0;
        model_reset();
        drive(mk_nop(), 1'b0);
        test_reset();
        test_addi();
        test_load_use();
        test_jal();
        test_flush_sw();
        test_forwarding();
        test_zero_dest();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
